// File: rtl/fir_float_pkg.sv
// Shared float10 format constants and the feeder FSM state encoding.
// float10 = {sign, exp[3:0] (bias 7), mant[4:0] (hidden leading one)}.
package fir_float_pkg;

  localparam int unsigned FLT_W    = 10;
  localparam int unsigned EXP_W    = 4;
  localparam int unsigned MAN_W    = 5;
  localparam int unsigned EXP_BIAS = 7;

  localparam logic [FLT_W-1:0] FLT_ZERO = '0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } feeder_state_e;

  function automatic logic [FLT_W-1:0] flt_pack(input logic             sign,
                                                input logic [EXP_W-1:0] exp_b,
                                                input logic [MAN_W-1:0] mant);
    return {sign, exp_b, mant};
  endfunction

endpackage

// File: rtl/fir_sample_feeder_if.sv
// Sample stream, filter control and status bundle of the FIR sample feeder.
// master = the side that drives samples and fir_done; slave = the feeder itself.
interface fir_sample_feeder_if #(
  parameter int unsigned DEPTH = 8
) ();

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          clr;
  logic          s_valid;
  logic [9:0]    s_data;
  logic          s_ready;
  logic [9:0]    fir_in;
  logic          fir_en;
  logic          fir_clr;
  logic          fir_done;
  logic          busy;
  logic [CW-1:0] count;
  logic          overflow;
  logic          timeout;

  modport master (
    output clr, s_valid, s_data, fir_done,
    input  s_ready, fir_in, fir_en, fir_clr, busy, count, overflow, timeout
  );

  modport slave (
    input  clr, s_valid, s_data, fir_done,
    output s_ready, fir_in, fir_en, fir_clr, busy, count, overflow, timeout
  );

endinterface

// File: rtl/fix_to_float10.sv
// Combinational Q0.9 signed fixed-point to float10 converter.
// Magnitudes below 8 flush to zero; mantissa is truncated, never rounded.
module fix_to_float10
  import fir_float_pkg::*;
(
  input  logic [FLT_W-1:0] i_fix,
  output logic [FLT_W-1:0] o_flt
);

  logic [FLT_W-1:0] w_mag;
  logic [FLT_W-1:0] w_shift;
  logic [3:0]       w_lead;
  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_mant;

  always_comb begin
    // -512 negates to 10'h200, which reads correctly as unsigned 512
    w_mag  = i_fix[FLT_W-1] ? (~i_fix + 1'b1) : i_fix;
    w_lead = '0;
    for (int i = 0; i < FLT_W; i++) begin
      if (w_mag[i]) begin
        w_lead = 4'(i);
      end
    end
    w_shift = w_mag << (4'd9 - w_lead);
    w_mant  = MAN_W'(w_shift >> 4);
    w_exp   = w_lead - 4'd2;
    if (w_mag < 10'd8) begin
      o_flt = FLT_ZERO;
    end else begin
      o_flt = flt_pack(i_fix[FLT_W-1], w_exp, w_mant);
    end
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Buffers converted ADC samples and hands them one at a time to an FIR filter.
// Optional WAIT watchdog is enabled by defining FEEDER_TIMEOUT_EN.
module fir_sample_feeder
  import fir_float_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned GUARD          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk_fast,
  input  logic         rst,
  fir_sample_feeder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [GW-1:0] GuardC = GW'(GUARD);

  logic [FLT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_d;
  logic             r_s_ready;
  logic [FLT_W-1:0] r_fir_in;
  logic             r_fir_clr;
  logic             r_overflow;
  logic [GW-1:0]    r_guard;
  logic [GW-1:0]    w_guard_d;
  feeder_state_e    r_state;
  feeder_state_e    w_state_d;
  logic [FLT_W-1:0] w_flt;
  logic             w_push;
  logic             w_pop;

`ifdef FEEDER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TimeoutLastC = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_wd;
  logic [TW-1:0] w_wd_d;
  logic          r_timeout;
  logic          w_to_set;
`endif

  fix_to_float10 u_conv (
    .i_fix (bus.s_data),
    .o_flt (w_flt)
  );

  // s_ready is registered, so acceptance never depends combinationally on s_valid
  assign w_push = bus.s_valid && r_s_ready && !bus.clr;
  assign w_pop  = (r_state == StIdle) && (r_count != '0) && !bus.clr;

  always_comb begin
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + 1'b1;
      2'b01:   w_count_d = r_count - 1'b1;
      default: w_count_d = r_count;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_guard_d = r_guard;
`ifdef FEEDER_TIMEOUT_EN
    w_wd_d    = r_wd;
    w_to_set  = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        if (r_count != '0) begin
          w_state_d = StIssue;
        end
      end
      StIssue: begin
        w_state_d = StWait;
        w_guard_d = '0;
`ifdef FEEDER_TIMEOUT_EN
        w_wd_d    = '0;
`endif
      end
      StWait: begin
        if (r_guard != GuardC) begin
          w_guard_d = r_guard + 1'b1;
        end
`ifdef FEEDER_TIMEOUT_EN
        w_wd_d = r_wd + 1'b1;
        if (bus.fir_done && (r_guard == GuardC)) begin
          w_state_d = StIdle;
        end else if (r_wd == TimeoutLastC) begin
          w_state_d = StIdle;
          w_to_set  = 1'b1;
        end
`else
        if (bus.fir_done && (r_guard == GuardC)) begin
          w_state_d = StIdle;
        end
`endif
      end
      default: w_state_d = StIdle;
    endcase
    if (bus.clr) begin
      w_state_d = StIdle;
    end
  end

  always_ff @(posedge clk_fast) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_s_ready  <= 1'b0;
      r_fir_in   <= FLT_ZERO;
      r_fir_clr  <= 1'b0;
      r_overflow <= 1'b0;
      r_guard    <= '0;
    end else begin
      r_state   <= w_state_d;
      r_guard   <= w_guard_d;
      r_fir_clr <= bus.clr;
      if (bus.clr) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_s_ready  <= 1'b1;
        r_fir_in   <= FLT_ZERO;
        r_overflow <= 1'b0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_fir_in <= r_mem[r_rd_ptr];
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        r_count   <= w_count_d;
        r_s_ready <= (w_count_d < DepthC);
        if (bus.s_valid && !r_s_ready) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_fast) begin
    if (rst && w_push) begin
      r_mem[r_wr_ptr] <= w_flt;
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  always_ff @(posedge clk_fast) begin
    if (!rst) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd <= w_wd_d;
      if (bus.clr) begin
        r_timeout <= 1'b0;
      end else if (w_to_set) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus.timeout = r_timeout;
`else
  // Watchdog absent: flag is constant low (parameter kept for a uniform interface)
  assign bus.timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  assign bus.s_ready  = r_s_ready;
  assign bus.fir_in   = r_fir_in;
  assign bus.fir_en   = (r_state == StIssue);
  assign bus.fir_clr  = r_fir_clr;
  assign bus.busy     = (r_state != StIdle);
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;

endmodule
